// File: rtl/line_pkg.sv
// Shared types and widths for the line drawing engine.
package line_pkg;

    localparam int unsigned H_RES_DEF   = 1280;
    localparam int unsigned V_RES_DEF   = 720;
    localparam int unsigned COLOR_W_DEF = 24;

    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned D_W   = 12;
    localparam int unsigned ERR_W = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Absolute difference of two zero-extended coordinates.
    function automatic logic [D_W-1:0] abs_diff(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/line_draw_engine_if.sv
// Pixel write port toward the framebuffer: valid/ready handshake carrying x, y and colour.
interface line_draw_engine_if
    import line_pkg::*;
#(
    parameter int unsigned COLOR_W = COLOR_W_DEF
);
    logic [X_W-1:0]     pixel_x_out;
    logic [Y_W-1:0]     pixel_y_out;
    logic [COLOR_W-1:0] pixel_color_out;
    logic               pixel_valid_out;
    logic               pixel_ready_in;

    modport master (
        output pixel_x_out,
        output pixel_y_out,
        output pixel_color_out,
        output pixel_valid_out,
        input  pixel_ready_in
    );

    modport slave (
        input  pixel_x_out,
        input  pixel_y_out,
        input  pixel_color_out,
        input  pixel_valid_out,
        output pixel_ready_in
    );
endinterface

// File: rtl/line_step.sv
// One Bresenham step: next x, y and error term from the current ones.
module line_step
    import line_pkg::*;
(
    input  logic [X_W-1:0]          x_i,
    input  logic [Y_W-1:0]          y_i,
    input  logic signed [ERR_W-1:0] err_i,
    input  logic [D_W-1:0]          dx_i,
    input  logic signed [ERR_W-1:0] dy_i,   // holds -|dy|
    input  logic                    sx_neg_i,
    input  logic                    sy_neg_i,
    output logic [X_W-1:0]          x_o,
    output logic [Y_W-1:0]          y_o,
    output logic signed [ERR_W-1:0] err_o
);
    logic signed [ERR_W:0]   e2;
    logic signed [ERR_W:0]   dx_w;
    logic signed [ERR_W:0]   dy_w;
    logic signed [ERR_W-1:0] dx_e;
    logic                    step_x;
    logic                    step_y;

    // Both comparisons use the pre-step error; the two increments sum.
    always_comb begin
        e2     = $signed({err_i, 1'b0});
        dx_w   = $signed({2'b00, dx_i});
        dy_w   = $signed({dy_i[ERR_W-1], dy_i});
        dx_e   = $signed({1'b0, dx_i});
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);

        err_o = err_i;
        x_o   = x_i;
        y_o   = y_i;
        if (step_x) begin
            err_o = err_o + dy_i;
            x_o   = sx_neg_i ? (x_i - X_W'(1)) : (x_i + X_W'(1));
        end
        if (step_y) begin
            err_o = err_o + dx_e;
            y_o   = sy_neg_i ? (y_i - Y_W'(1)) : (y_i + Y_W'(1));
        end
    end
endmodule

// File: rtl/line_draw_engine.sv
// All-octant Bresenham line writer emitting one framebuffer pixel per handshake.
module line_draw_engine
    import line_pkg::*;
#(
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned COLOR_W = COLOR_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic [X_W-1:0]     x1_in,
    input  logic [X_W-1:0]     x2_in,
    input  logic [Y_W-1:0]     y1_in,
    input  logic [Y_W-1:0]     y2_in,
    input  logic [COLOR_W-1:0] color_in,
    line_draw_engine_if.master pix,
    output logic               busy_out,
    output logic               done_out
);
    state_t                  state_q, state_d;
    logic [X_W-1:0]          x_q, x_d, x2_q, x2_d;
    logic [Y_W-1:0]          y_q, y_d, y2_q, y2_d;
    logic [COLOR_W-1:0]      color_q, color_d;
    logic [D_W-1:0]          dx_q, dx_d;
    logic signed [ERR_W-1:0] dy_q, dy_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic                    sx_neg_q, sx_neg_d;
    logic                    sy_neg_q, sy_neg_d;

    logic [X_W-1:0]          x_nx;
    logic [Y_W-1:0]          y_nx;
    logic signed [ERR_W-1:0] err_nx;
    logic [D_W-1:0]          dx_w;
    logic [D_W-1:0]          ady_w;
    logic                    on_screen;
    logic                    advance;
    logic                    at_end;

    line_step u_step (
        .x_i      (x_q),
        .y_i      (y_q),
        .err_i    (err_q),
        .dx_i     (dx_q),
        .dy_i     (dy_q),
        .sx_neg_i (sx_neg_q),
        .sy_neg_i (sy_neg_q),
        .x_o      (x_nx),
        .y_o      (y_nx),
        .err_o    (err_nx)
    );

    // Outputs decode registered state only; ready never reaches an output.
    always_comb begin
        on_screen           = (32'(x_q) < H_RES) && (32'(y_q) < V_RES);
        pix.pixel_x_out     = x_q;
        pix.pixel_y_out     = y_q;
        pix.pixel_color_out = color_q;
        pix.pixel_valid_out = (state_q == DRAW) && on_screen;
        busy_out            = (state_q == DRAW);
        done_out            = (state_q == DONE);
    end

    // Next-state logic: latch a line in IDLE, walk it in DRAW, pulse DONE.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x2_d     = x2_q;
        y2_d     = y2_q;
        color_d  = color_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;

        dx_w    = abs_diff({1'b0, x2_in}, {1'b0, x1_in});
        ady_w   = abs_diff({2'b00, y2_in}, {2'b00, y1_in});
        advance = (state_q == DRAW) && (!on_screen || pix.pixel_ready_in);
        at_end  = (x_q == x2_q) && (y_q == y2_q);

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    x_d      = x1_in;
                    y_d      = y1_in;
                    x2_d     = x2_in;
                    y2_d     = y2_in;
                    color_d  = color_in;
                    dx_d     = dx_w;
                    dy_d     = -$signed({1'b0, ady_w});
                    err_d    = $signed({1'b0, dx_w}) - $signed({1'b0, ady_w});
                    sx_neg_d = (x2_in < x1_in);
                    sy_neg_d = (y2_in < y1_in);
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        x_d   = x_nx;
                        y_d   = y_nx;
                        err_d = err_nx;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            color_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            x2_q     <= x2_d;
            y2_q     <= y2_d;
            color_q  <= color_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end
endmodule
